// File: rtl/pipelined_mem_responder.sv
// Main-memory model that sits below the cache fill FSMs.
// It accepts one word read or write on every cycle and never stalls.
// Read data comes back after exactly LATENCY cycles, as a one-cycle data_valid pulse.
// Storage is a 2^ADDR_W x 16 word array indexed by addr[ADDR_W:1].
// The storage is not reset, so writes survive a reset; the read pipeline and counter are reset.
module pipelined_mem_responder #(
    parameter int ADDR_W  = 15,   // word-address width, at most 15
    parameter int LATENCY = 4     // read acceptance to data_valid, 1..8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [3:0]  rd_outstanding
);

    localparam int DEPTH = 1 << ADDR_W;

    // One in-flight read: its valid flag and the word captured when it was accepted.
    typedef struct packed {
        logic        vld;
        logic [15:0] data;
    } rd_slot_t;

    logic [15:0]                 mem [DEPTH];
    logic [ADDR_W-1:0]           word_idx;
    logic                        rd_acc;
    logic                        wr_acc;
    logic                        rd_ret;
    rd_slot_t [LATENCY-1:0]      pipe_q;
    rd_slot_t [LATENCY-1:0]      pipe_d;
    logic [3:0]                  rd_cnt_q;
    logic [3:0]                  rd_cnt_d;

    // Bit 0 is the byte lane and is dropped.
    // Bits above ADDR_W are ignored, so addresses alias.
    assign word_idx = addr[ADDR_W:1];

    // Request decode, pipeline shift and the outstanding-read counter update.
    always_comb begin
        rd_acc = enable & ~wr;
        wr_acc = enable & wr;
        rd_ret = pipe_q[LATENCY-1].vld;

        // The memory read is sampled here, combinationally, before the write port updates the array.
        // A read therefore captures the word as it was before this edge.
        // Later writes cannot disturb a read that is already in flight.
        pipe_d[0].vld  = rd_acc;
        pipe_d[0].data = rd_acc ? mem[word_idx] : 16'h0000;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // An accept and a retire on the same edge cancel out.
        // The count can never exceed LATENCY, because each pipeline stage holds at most one read.
        rd_cnt_d = rd_cnt_q + {3'b000, rd_acc} - {3'b000, rd_ret};
    end

    // Pipeline and counter registers.
    // Reset drops every in-flight read immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q   <= '0;
            rd_cnt_q <= 4'd0;
        end else begin
            pipe_q   <= pipe_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Storage write port.
    // It has no reset, so contents persist across a reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[word_idx] <= data_in;
        end
    end

    // The last pipeline stage drives the response.
    // Data is forced to zero whenever no valid is being presented.
    always_comb begin
        data_valid     = pipe_q[LATENCY-1].vld;
        data_out       = pipe_q[LATENCY-1].vld ? pipe_q[LATENCY-1].data : 16'h0000;
        rd_outstanding = rd_cnt_q;
    end

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Bench for pipelined_mem_responder.
// Two builds are driven with the same stimulus: the default build (ADDR_W=15, LATENCY=4) and a small build (ADDR_W=7, LATENCY=1).
// Each build is compared every cycle against a cycle-stamped model of reads and a word-map model of memory.
module tb_pipelined_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] dout0, dout1;
    logic        dv0, dv1;
    logic [3:0]  ro0, ro1;

    always #5 clk = ~clk;

    pipelined_mem_responder #(.ADDR_W(15), .LATENCY(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dout0), .data_valid(dv0), .rd_outstanding(ro0));

    pipelined_mem_responder #(.ADDR_W(7), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dout1), .data_valid(dv1), .rd_outstanding(ro1));

    // A pending read: which build it belongs to, the cycle it is due back, and the word it should return.
    typedef struct {
        int          dut;
        int          due;
        logic [15:0] data;
        bit          known;
    } rd_t;

    rd_t         pend[$];
    logic [15:0] mem_m [int];
    logic [15:0] pool  [12];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    // Model memory key: the build number in the upper bits, plus the word index that build decodes.
    function automatic int midx(int d, logic [15:0] a);
        return d * 65536 + ((d == 0) ? int'(a[15:1]) : int'(a[7:1]));
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Compare one build's outputs for the current cycle against the model.
    task automatic check_dut(int d);
        logic        ev;
        logic [15:0] ed;
        bit          kn;
        int          cnt;
        ev = 1'b0; ed = 16'h0000; kn = 1'b1; cnt = 0;
        foreach (pend[i]) begin
            if (pend[i].dut == d) begin
                if (pend[i].due >= cyc) cnt++;
                if (pend[i].due == cyc) begin
                    ev = 1'b1; ed = pend[i].data; kn = pend[i].known;
                end
            end
        end
        chk($sformatf("valid%0d", d), {15'b0, (d == 0) ? dv0 : dv1}, {15'b0, ev});
        chk($sformatf("outstanding%0d", d), {12'b0, (d == 0) ? ro0 : ro1}, 16'(cnt));
        if (kn) chk($sformatf("data%0d", d), (d == 0) ? dout0 : dout1, ed);
    endtask

    // One clock cycle. Check this cycle's outputs, drive a request, then record what the edge accepted.
    task automatic step(bit en, bit w, logic [15:0] a, logic [15:0] di);
        rd_t r;
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].due <= cyc) pend.delete(i);
        enable  = en;
        wr      = en ? w : 1'bx;
        addr    = en ? a : 16'hxxxx;
        data_in = di;
        @(posedge clk);
        if (en) begin
            for (int d = 0; d < 2; d++) begin
                if (w) mem_m[midx(d, a)] = di;
                else begin
                    r.dut   = d;
                    r.due   = cyc + lat(d);
                    r.known = mem_m.exists(midx(d, a));
                    r.data  = r.known ? mem_m[midx(d, a)] : 16'h0000;
                    pend.push_back(r);
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Reset for one cycle. Outputs must clear asynchronously, and all in-flight reads are dropped.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("rst_valid0", {15'b0, dv0}, 16'h0000);
        chk("rst_data0", dout0, 16'h0000);
        chk("rst_out0", {12'b0, ro0}, 16'h0000);
        chk("rst_valid1", {15'b0, dv1}, 16'h0000);
        chk("rst_data1", dout1, 16'h0000);
        chk("rst_out1", {12'b0, ro1}, 16'h0000);
        pend.delete();
        @(posedge clk);
        cyc++;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid0", {15'b0, dv0}, 16'h0000);
        chk("init_data0", dout0, 16'h0000);
        chk("init_out0", {12'b0, ro0}, 16'h0000);
        chk("init_valid1", {15'b0, dv1}, 16'h0000);
        rst_n = 1'b1;

        // Single write, then a read back of the same word.
        step(1'b1, 1'b1, 16'h0040, 16'hBEEF);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        idle(6);

        // Eight writes followed by an 8-beat read burst.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h1230 + 2 * i), 16'(16'h1110 + i));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(16'h1230 + 2 * i), 16'h0000);
        idle(6);

        // Snapshot: the first read keeps the old word, a read after the write sees the new word.
        step(1'b1, 1'b1, 16'h0010, 16'h1111);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        step(1'b1, 1'b1, 16'h0010, 16'h2222);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(6);

        // Reset in the middle of a burst. Reads in flight are lost, but storage survives.
        step(1'b1, 1'b0, 16'h1230, 16'h0000);
        step(1'b1, 1'b0, 16'h1232, 16'h0000);
        step(1'b1, 1'b0, 16'h1234, 16'h0000);
        pulse_reset();
        idle(8);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        step(1'b1, 1'b0, 16'h1236, 16'h0000);
        idle(5);

        // Odd addresses and aliasing. In the small build, 0x0102 and 0x0002 are the same word.
        step(1'b1, 1'b1, 16'h0003, 16'hA5A5);
        step(1'b1, 1'b0, 16'h0002, 16'h0000);
        step(1'b1, 1'b1, 16'h0102, 16'h7777);
        step(1'b1, 1'b1, 16'h0002, 16'h5A5A);
        step(1'b1, 1'b0, 16'h0102, 16'h0000);
        step(1'b1, 1'b0, 16'h0103, 16'h0000);
        idle(5);

        // Random traffic over a small address pool. The low bits repeat, so the small build sees aliases.
        for (int k = 0; k < 12; k++) begin
            pool[k] = {8'($urandom), 7'(k % 6), 1'b0};
            step(1'b1, 1'b1, pool[k], 16'($urandom));
        end
        for (int n = 0; n < 400; n++) begin
            logic        en;
            logic        w;
            logic [15:0] a;
            en = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 9) < 3);
            a  = pool[$urandom_range(0, 11)] | 16'($urandom_range(0, 1));
            step(en, w, a, 16'($urandom));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
